// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - read-side controller draining a FIFO into a 2-entry skid buffer and valid/ready stream
// Optional FIFO_READER_STATS_EN adds the rd_count read counter output.
module fifo_reader #(
  parameter int DATA_W    = 6,
  parameter int TIMEOUT   = 8,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic              al_empty,
  input  logic              err_fifo,
  input  logic [DATA_W-1:0] data_out,
  output logic              fifo_rd,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              rd_err
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [15:0]       rd_count
`endif
);

  typedef enum logic [1:0] {IDLE, BURST, FLUSH, ERR} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state_q;
  logic [7:0]        cnt_q;
  logic              rd_err_q;
  logic              inflight_q;
  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic [DATA_W-1:0] mem_d [BUF_DEPTH];

  logic       pop, push, credit_ok, rd_state;
  logic [2:0] occ;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[0];
  assign rd_err    = rd_err_q;
  assign pop       = out_valid & out_ready;
  assign push      = inflight_q;

  // Occupancy once this cycle's pop and the arriving in-flight word settle; a new read needs a free slot.
  assign occ       = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign credit_ok = (occ < 3'd2);
  assign rd_state  = ((state_q == BURST) && !al_empty) || (state_q == FLUSH);
  assign fifo_rd   = rd_state && credit_ok && !fifo_empty && enable && !err_fifo;

  always_comb begin
    count_d = count_q;
    mem_d   = mem_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) mem_d[0] = data_out;
        else                 mem_d[1] = data_out;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        mem_d[0] = mem_q[1];
        count_d  = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          mem_d[0] = data_out;
        end else begin
          mem_d[0] = mem_q[1];
          mem_d[1] = data_out;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      inflight_q <= fifo_rd;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      rd_err_q <= 1'b0;
    end else if (err_fifo) begin
      state_q  <= ERR;
      cnt_q    <= 8'd0;
      rd_err_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable && !al_empty) begin
            state_q <= BURST;
            cnt_q   <= 8'd0;
          end else if (enable && !fifo_empty && cnt_q == TO_LAST) begin
            state_q <= FLUSH;
            cnt_q   <= 8'd0;
          end else if (enable && !fifo_empty && al_empty) begin
            cnt_q <= cnt_q + 8'd1;
          end else begin
            cnt_q <= 8'd0;
          end
        end
        BURST: if (al_empty || !enable) state_q <= IDLE;
        FLUSH: if (fifo_empty || !enable) state_q <= IDLE;
        ERR:   state_q <= ERR;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FIFO_READER_STATS_EN
  logic [15:0] rd_count_q;

  assign rd_count = rd_count_q;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      rd_count_q <= 16'd0;
    end else if (fifo_rd && state_q != ERR) begin
      rd_count_q <= rd_count_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - directed bench for fifo_reader with a behavioural FIFO model
module tb_fifo_reader;

  logic       clk;
  logic       RESET;
  logic       enable;
  logic       fifo_empty;
  logic       al_empty;
  logic       err_fifo;
  logic [5:0] data_out;
  logic       fifo_rd;
  logic       out_valid;
  logic [5:0] out_data;
  logic       out_ready;
  logic       rd_err;
`ifdef FIFO_READER_STATS_EN
  logic [15:0] rd_count;
`endif

  fifo_reader #(.DATA_W(6), .TIMEOUT(8), .BUF_DEPTH(2)) dut (
    .clk        (clk),
    .RESET      (RESET),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .al_empty   (al_empty),
    .err_fifo   (err_fifo),
    .data_out   (data_out),
    .fifo_rd    (fifo_rd),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .rd_err     (rd_err)
`ifdef FIFO_READER_STATS_EN
    ,
    .rd_count   (rd_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] fq [$];
  logic [5:0] got [$];
  int         rd_pulses;
  int         cyc;
  int         first_rd;
  int         first_vld;
  int         underflow;
  int         vectors;
  int         miscompares;
  bit         refill;
  logic [5:0] next_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_flags();
    fifo_empty = (fq.size() == 0);
    al_empty   = (fq.size() <= 2);
  endtask

  task automatic clear_obs();
    rd_pulses = 0;
    got.delete();
    first_rd  = -1;
    first_vld = -1;
  endtask

  // One clock: sample DUT at negedge, then update the FIFO model just after posedge.
  task automatic tick();
    logic       rd;
    logic       acc;
    logic [5:0] od;
    @(negedge clk);
    rd  = fifo_rd;
    acc = out_valid & out_ready;
    od  = out_data;
    if (acc) got.push_back(od);
    if (rd) rd_pulses++;
    if (rd && first_rd < 0) first_rd = cyc;
    if (out_valid && first_vld < 0) first_vld = cyc;
    @(posedge clk);
    #1;
    cyc++;
    if (rd) begin
      if (fq.size() == 0) underflow++;
      else data_out = fq.pop_front();
    end
    if (refill) begin
      while (fq.size() < 8) begin
        fq.push_back(next_w);
        next_w = next_w + 6'd1;
      end
    end
    set_flags();
  endtask

  initial begin
    RESET = 1'b1; enable = 1'b0; err_fifo = 1'b0; out_ready = 1'b0; data_out = 6'h00;
    vectors = 0; miscompares = 0; cyc = 0; underflow = 0; refill = 1'b0; next_w = 6'h00;
    clear_obs();
    set_flags();
    #12;
    chk("reset_fifo_rd", {31'b0, fifo_rd}, 0);
    chk("reset_out_valid", {31'b0, out_valid}, 0);
    chk("reset_out_data", {26'b0, out_data}, 0);
    chk("reset_rd_err", {31'b0, rd_err}, 0);
    @(posedge clk);
    #1;
    RESET = 1'b0;

    // Burst drain of 6 words stops once almost-empty (2 left)
    fq = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06};
    set_flags();
    clear_obs();
    enable = 1'b1; out_ready = 1'b1;
    repeat (10) tick();
    chk("burst_reads", rd_pulses, 4);
    chk("burst_count", got.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("burst_word%0d", i), {26'b0, got[i]}, i + 1);
    chk("burst_latency", first_vld - first_rd, 2);
    enable = 1'b0;
    tick();
    fq.delete();
    set_flags();

    // Timeout flush of a two-word residue
    fq = '{6'h2A, 6'h15};
    set_flags();
    clear_obs();
    enable = 1'b1;
    repeat (8) tick();
    chk("timeout_quiet", rd_pulses, 0);
    repeat (6) tick();
    chk("flush_reads", rd_pulses, 2);
    chk("flush_count", got.size(), 2);
    chk("flush_word0", {26'b0, got[0]}, 32'h2A);
    chk("flush_word1", {26'b0, got[1]}, 32'h15);
    chk("flush_rd_idle", {31'b0, fifo_rd}, 0);
    enable = 1'b0;
    tick();

    // Backpressure: only two reads outstanding, then one word per cycle
    fq = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16, 6'h17};
    set_flags();
    clear_obs();
    out_ready = 1'b0; enable = 1'b1;
    repeat (12) tick();
    chk("bp_reads", rd_pulses, 2);
    chk("bp_valid", {31'b0, out_valid}, 1);
    chk("bp_hold_data", {26'b0, out_data}, 32'h10);
    chk("bp_none_taken", got.size(), 0);
    out_ready = 1'b1;
    repeat (6) tick();
    chk("bp_stream_count", got.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("bp_word%0d", i), {26'b0, got[i]}, 32'h10 + i);
    enable = 1'b0;
    repeat (3) tick();
    fq.delete();
    set_flags();

    // Error mid-burst: reads stop immediately, buffered words still delivered
    fq = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27};
    set_flags();
    clear_obs();
    enable = 1'b1;
    repeat (4) tick();
    err_fifo = 1'b1;
    #1;
    chk("err_rd_same_cycle", {31'b0, fifo_rd}, 0);
    tick();
    err_fifo = 1'b0;
    repeat (10) tick();
    chk("err_reads", rd_pulses, 3);
    chk("err_sticky", {31'b0, rd_err}, 1);
    chk("err_drain_count", got.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("err_word%0d", i), {26'b0, got[i]}, 32'h20 + i);
    RESET = 1'b1;
    #1;
    chk("err_cleared_by_reset", {31'b0, rd_err}, 0);
    repeat (2) tick();
    RESET = 1'b0;
    fq.delete();
    set_flags();

    // Asynchronous reset while streaming discards buffered and in-flight words
    fq = '{6'h30, 6'h31, 6'h32, 6'h33, 6'h34, 6'h35, 6'h36, 6'h37};
    set_flags();
    clear_obs();
    enable = 1'b1; out_ready = 1'b1;
    repeat (3) tick();
    chk("pre_reset_rd", {31'b0, fifo_rd}, 1);
    chk("pre_reset_valid", {31'b0, out_valid}, 1);
    #2;
    RESET = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 0);
    chk("async_rst_rd", {31'b0, fifo_rd}, 0);
    chk("async_rst_err", {31'b0, rd_err}, 0);
    repeat (2) tick();
    RESET = 1'b0;
    chk("post_reset_empty", {31'b0, out_valid}, 0);
    clear_obs();
    repeat (10) tick();
    chk("restart_count", got.size(), 4);
    chk("restart_first", {26'b0, got[0]}, 32'h32);
    chk("restart_last", {26'b0, got[3]}, 32'h35);
    chk("no_underflow", underflow, 0);
    enable = 1'b0;
    tick();

`ifdef FIFO_READER_STATS_EN
    RESET = 1'b1;
    #1;
    chk("stats_reset", {16'b0, rd_count}, 0);
    tick();
    RESET = 1'b0;
    fq.delete();
    refill = 1'b1;
    next_w = 6'h00;
    while (fq.size() < 8) begin
      fq.push_back(next_w);
      next_w = next_w + 6'd1;
    end
    set_flags();
    clear_obs();
    out_ready = 1'b1; enable = 1'b1;
    begin
      int guard;
      guard = 0;
      while (rd_pulses < 70000 && guard < 80000) begin
        tick();
        guard++;
        if (got.size() > 64) got.delete();
      end
      enable = 1'b0;
      chk("stats_within_budget", {31'b0, guard < 80000}, 1);
    end
    tick();
    chk("stats_wrap", {16'b0, rd_count}, 4464);
    refill = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
